// File: rtl/valve_seq_pkg.sv
// Shared encodings for the valve sequencer: opcodes, instruction field positions,
// delay units with their base-tick counts, FSM states and the delay counter payload.
package valve_seq_pkg;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned UNIT_MSB = 12;
  localparam int unsigned UNIT_LSB = 10;
  localparam int unsigned CNT_MSB  = 9;
  localparam int unsigned CNT_LSB  = 0;
  localparam int unsigned IDX_MSB  = 7;
  localparam int unsigned IDX_LSB  = 0;

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned UNIT_W = 3;
  localparam int unsigned SUB_W  = 22;
  localparam int unsigned REM_W  = 10;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_SET   = 3'b001,
    OP_CLR   = 3'b010,
    OP_DELAY = 3'b011,
    OP_JUMP  = 3'b100,
    OP_ILL5  = 3'b101,
    OP_ILL6  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  localparam logic [1:0] UNIT_MS  = 2'd0;
  localparam logic [1:0] UNIT_S   = 2'd1;
  localparam logic [1:0] UNIT_MIN = 2'd2;
  localparam logic [1:0] UNIT_H   = 2'd3;

  localparam logic [SUB_W-1:0] TICKS_MS  = 22'd1;
  localparam logic [SUB_W-1:0] TICKS_S   = 22'd1000;
  localparam logic [SUB_W-1:0] TICKS_MIN = 22'd60000;
  localparam logic [SUB_W-1:0] TICKS_H   = 22'd3600000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DELAY  = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef struct packed {
    logic [REM_W-1:0] remaining;
    logic [SUB_W-1:0] sub;
    logic [1:0]       unit;
  } delay_cnt_t;

  function automatic logic [SUB_W-1:0] unit_ticks(input logic [1:0] unit);
    case (unit)
      UNIT_MS:  return TICKS_MS;
      UNIT_S:   return TICKS_S;
      UNIT_MIN: return TICKS_MIN;
      default:  return TICKS_H;
    endcase
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Base-tick prescaler: one-cycle tick every TICK_DIV enabled cycles; clear wins over enable.
module seq_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/valve_sequencer.sv
// Program-driven valve sequencer: fetches 16-bit instructions from a synchronous
// memory, drives an N-valve open/closed vector and runs exact-length timed delays.
module valve_sequencer
  import valve_seq_pkg::*;
#(
  parameter int unsigned N_VALVES = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [N_VALVES-1:0] valve_state,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                delay_active,
  output logic [ADDR_W-1:0]   pc_out
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d, pc_inc;
  logic [N_VALVES-1:0]   valve_d;
  delay_cnt_t            dly_q, dly_d;
  logic                  presc_clr_c, presc_en_c, tick_c;

  opcode_e               op;
  logic [UNIT_W-1:0]     unit_raw;
  logic [REM_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  idx_ok, unit_ok;

  assign op       = opcode_e'(imem_rdata[OP_MSB:OP_LSB]);
  assign unit_raw = imem_rdata[UNIT_MSB:UNIT_LSB];
  assign cnt      = imem_rdata[CNT_MSB:CNT_LSB];
  assign idx      = imem_rdata[IDX_MSB:IDX_LSB];
  assign idx_ok   = (32'(idx) < N_VALVES);
  assign unit_ok  = (unit_raw < UNIT_W'(4));
  assign pc_inc   = pc_q + ADDR_W'(1);

  // The memory address is the pc itself, so it holds whenever the pc holds.
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (presc_clr_c),
    .en     (presc_en_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valve_d     = valve_state;
    dly_d       = dly_q;
    presc_clr_c = 1'b0;
    presc_en_c  = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      pc_d        = '0;
      valve_d     = '0;
      dly_d       = '0;
      presc_clr_c = 1'b1;
    end else if (!pause) begin
      case (state_q)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = '0;
          end
        end

        ST_FETCH: state_d = ST_EXEC;

        ST_EXEC: begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
          case (op)
            OP_NOP: ;
            OP_SET, OP_CLR: begin
              if (idx_ok) begin
                for (int unsigned i = 0; i < N_VALVES; i++) begin
                  if (idx == IDX_W'(i)) valve_d[i] = (op == OP_SET);
                end
              end else begin
                state_d = ST_ERROR;
                pc_d    = pc_q;
              end
            end
            OP_DELAY: begin
              if (!unit_ok) begin
                state_d = ST_ERROR;
                pc_d    = pc_q;
              end else if (cnt != '0) begin
                state_d         = ST_DELAY;
                pc_d            = pc_q;
                presc_clr_c     = 1'b1;
                dly_d.remaining = cnt;
                dly_d.unit      = unit_raw[1:0];
                dly_d.sub       = unit_ticks(unit_raw[1:0]);
              end
            end
            OP_JUMP: pc_d = imem_rdata[ADDR_W-1:0];
            OP_HALT: begin
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end
            default: begin
              state_d = ST_ERROR;
              pc_d    = pc_q;
            end
          endcase
        end

        // Sub-counter walks the unit's ticks; remaining counts whole units.
        ST_DELAY: begin
          presc_en_c = 1'b1;
          if (tick_c) begin
            if (dly_q.sub == SUB_W'(1)) begin
              if (dly_q.remaining == REM_W'(1)) begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                dly_d   = '0;
              end else begin
                dly_d.remaining = dly_q.remaining - REM_W'(1);
                dly_d.sub       = unit_ticks(dly_q.unit);
              end
            end else begin
              dly_d.sub = dly_q.sub - SUB_W'(1);
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      valve_state  <= '0;
      dly_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      delay_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valve_state  <= valve_d;
      dly_q        <= dly_d;
      busy         <= (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_DELAY);
      done         <= (state_d == ST_HALTED);
      err          <= (state_d == ST_ERROR);
      delay_active <= (state_d == ST_DELAY);
    end
  end

endmodule

// File: tb/tb_valve_sequencer.sv
// Directed bench for valve_sequencer with TICK_DIV=4 and four valves; memory model is a
// synchronous ROM the bench loads between programs.
module tb_valve_sequencer;

  localparam int unsigned N_VALVES = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned CLK_HZ   = 4000;
  localparam int unsigned TICK_HZ  = 1000;

  localparam logic [15:0] I_HALT = 16'hE000;
  localparam logic [15:0] I_OP5  = 16'hA000;

  logic                clk = 1'b0;
  logic                rst, start, abort, pause;
  logic [ADDR_W-1:0]   imem_addr, pc_out;
  logic [INSTR_W-1:0]  imem_rdata = '0;
  logic [N_VALVES-1:0] valve_state;
  logic                busy, done, err, delay_active;

  logic [15:0] mem [256];
  int n_assert = 0;
  int n_fail   = 0;
  int da_cnt, pre_cnt, post_cnt;

  valve_sequencer #(
    .N_VALVES (N_VALVES),
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pause        (pause),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .valve_state  (valve_state),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .delay_active (delay_active),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [15:0] enc_set(input logic [7:0] i);
    return {3'b001, 5'd0, i};
  endfunction
  function automatic logic [15:0] enc_clr(input logic [7:0] i);
    return {3'b010, 5'd0, i};
  endfunction
  function automatic logic [15:0] enc_dly(input logic [2:0] u, input logic [9:0] c);
    return {3'b011, u, c};
  endfunction
  function automatic logic [15:0] enc_jmp(input logic [7:0] t);
    return {3'b100, 5'd0, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = I_HALT;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    fill_halt();
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {20'd0, valve_state, busy, done, err, delay_active}, 32'd0);
    check("reset_pc", {24'd0, pc_out}, 32'd0);
    check("reset_addr", {24'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    check("idle_without_start", {31'd0, busy}, 32'd0);

    // Program 1: SET 0, SET 3, HALT
    mem[0] = enc_set(8'd0); mem[1] = enc_set(8'd3); mem[2] = I_HALT;
    pulse_start();
    check("p1_busy", {31'd0, busy}, 32'd1);
    cycles(2);
    check("p1_valve_a", {28'd0, valve_state}, 32'h1);
    cycles(2);
    check("p1_valve_b", {28'd0, valve_state}, 32'h9);
    cycles(1);
    check("p1_done_c5", {31'd0, done}, 32'd0);
    cycles(1);
    check("p1_done_c6", {31'd0, done}, 32'd1);
    check("p1_busy_end", {31'd0, busy}, 32'd0);
    check("p1_pc", {24'd0, pc_out}, 32'd2);

    // Program 2: SET 1, DELAY 5 ms, CLR 1, HALT
    fill_halt();
    mem[0] = enc_set(8'd1); mem[1] = enc_dly(3'd0, 10'd5); mem[2] = enc_clr(8'd1);
    pulse_start();
    da_cnt = 0; pre_cnt = 0; post_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (delay_active) da_cnt++;
      else if (valve_state[1]) begin
        if (da_cnt == 0) pre_cnt++;
        else post_cnt++;
      end
    end
    check("p2_open_before_delay", 32'(pre_cnt), 32'd2);
    check("p2_delay_cycles", 32'(da_cnt), 32'd20);
    check("p2_open_after_delay", 32'(post_cnt), 32'd2);
    check("p2_done", {31'd0, done}, 32'd1);
    check("p2_valve_end", {28'd0, valve_state}, 32'h9);
    check("p2_pc", {24'd0, pc_out}, 32'd3);

    // Program 3: SET 2, DELAY 2 s with a 37-cycle pause mid-delay, HALT
    fill_halt();
    mem[0] = enc_set(8'd2); mem[1] = enc_dly(3'd1, 10'd2);
    pulse_start();
    da_cnt = 0;
    for (int i = 1; i <= 8100; i++) begin
      @(negedge clk);
      if (delay_active) da_cnt++;
      if (i == 140) begin
        check("p3_pause_pc", {24'd0, pc_out}, 32'd1);
        check("p3_pause_valve", {28'd0, valve_state}, 32'hD);
        check("p3_pause_delay_active", {31'd0, delay_active}, 32'd1);
      end
      if (i == 104) pause = 1'b1;
      if (i == 141) pause = 1'b0;
    end
    check("p3_delay_cycles", 32'(da_cnt), 32'd8037);
    check("p3_done", {31'd0, done}, 32'd1);
    check("p3_pc", {24'd0, pc_out}, 32'd2);

    // Program 4: SET 2, CLR 2, JUMP 0 aborted with a simultaneous start
    fill_halt();
    mem[0] = enc_set(8'd2); mem[1] = enc_clr(8'd2); mem[2] = enc_jmp(8'd0);
    pulse_start();
    cycles(19);
    check("p4_looping_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("p4_abort_flags", {28'd0, busy, done, err, delay_active}, 32'd0);
    check("p4_abort_valve", {28'd0, valve_state}, 32'd0);
    check("p4_abort_pc", {24'd0, pc_out}, 32'd0);
    cycles(3);
    check("p4_start_ignored", {31'd0, busy}, 32'd0);

    // Error traps: bad valve index, illegal opcode, bad delay unit
    fill_halt();
    mem[0] = enc_set(8'd0); mem[1] = enc_set(8'd4);
    pulse_start();
    cycles(2);
    check("p5a_valve_pre", {28'd0, valve_state}, 32'h1);
    check("p5a_err_pre", {31'd0, err}, 32'd0);
    cycles(2);
    check("p5a_err", {30'd0, err, busy}, 32'h2);
    check("p5a_valve", {28'd0, valve_state}, 32'h1);
    check("p5a_pc", {24'd0, pc_out}, 32'd1);
    mem[0] = enc_set(8'd1); mem[1] = I_OP5;
    pulse_start();
    check("p5b_err_cleared", {31'd0, err}, 32'd0);
    cycles(4);
    check("p5b_err", {31'd0, err}, 32'd1);
    check("p5b_valve", {28'd0, valve_state}, 32'h3);
    mem[0] = enc_clr(8'd0); mem[1] = enc_dly(3'd5, 10'd3);
    pulse_start();
    cycles(4);
    check("p5c_err", {30'd0, err, delay_active}, 32'h2);
    check("p5c_valve", {28'd0, valve_state}, 32'h2);

    // Reset during a 1-minute delay, then a zero-count delay
    fill_halt();
    mem[0] = enc_set(8'd3); mem[1] = enc_dly(3'd2, 10'd1);
    pulse_start();
    cycles(4);
    check("p6_in_delay", {31'd0, delay_active}, 32'd1);
    check("p6_valve_pre", {28'd0, valve_state}, 32'hA);
    cycles(10);
    #2 rst = 1'b0;
    #1 check("p6_async_reset", {12'd0, valve_state, busy, done, err, delay_active, pc_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(5);
    check("p6_idle_after_reset", {27'd0, busy, done, err, delay_active, 1'b0}, 32'd0);
    check("p6_pc_after_reset", {24'd0, pc_out}, 32'd0);
    mem[0] = enc_dly(3'd0, 10'd0); mem[1] = I_HALT;
    pulse_start();
    cycles(2);
    check("p6_dly0_pc", {24'd0, pc_out}, 32'd1);
    check("p6_dly0_flags", {30'd0, busy, delay_active}, 32'h2);
    cycles(2);
    check("p6_dly0_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
